// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared op codes, FSM states and memory geometry
package mem_pkg;

  localparam int MEM_DATA_W     = 26;
  localparam int MEM_ADDR_W     = 26;
  localparam int MEM_DEPTH      = 8;
  localparam int MEM_DEPTH_LOG2 = 3;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_SWP_B,
    ST_SWP_A,
    ST_CLR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - request sequencer driving the shared data-memory port
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> DEPTH_LOG2) == '0;
  endfunction

  state_e                r_state;
  op_e                   r_op;
  logic [DEPTH_LOG2-1:0] r_addr_a;
  logic [DEPTH_LOG2-1:0] r_addr_b;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_tmp_a;
  logic [DATA_W-1:0]     r_tmp_b;
  logic [DATA_W-1:0]     r_resp_data;
  logic                  r_resp_err;

  op_e  w_op;
  logic w_fire;
  logic w_ok;

  assign w_op   = op_e'(req_op);
  assign w_fire = req_valid && (r_state == ST_IDLE);
  assign w_ok   = in_range(req_addr_a) && ((w_op != OP_SWAP) || in_range(req_addr_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_READ;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_tmp_a     <= '0;
      r_tmp_b     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_fire) begin
          r_op        <= w_op;
          r_addr_a    <= req_addr_a[DEPTH_LOG2-1:0];
          r_addr_b    <= req_addr_b[DEPTH_LOG2-1:0];
          r_wdata     <= req_wdata;
          r_cnt       <= '0;
          r_resp_data <= '0;
          r_resp_err  <= 1'b0;
          if (w_op == OP_CLEAR) begin
            r_state <= ST_CLR;
          end else if (!w_ok) begin
            r_resp_err <= 1'b1;
            r_state    <= ST_RESP;
          end else if (w_op == OP_WRITE) begin
            r_state <= ST_WR;
          end else begin
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          r_tmp_a <= mem_rdata;
          if (r_op == OP_SWAP) begin
            r_state <= ST_SWP_B;
          end else begin
            r_resp_data <= mem_rdata;
            r_state     <= ST_RESP;
          end
        end
        // mem[b] is overwritten at the end of this cycle, so its old value is captured now
        ST_SWP_B: begin
          r_tmp_b <= mem_rdata;
          r_state <= ST_SWP_A;
        end
        ST_SWP_A: begin
          r_resp_data <= r_tmp_a;
          r_state     <= ST_RESP;
        end
        ST_WR: r_state <= ST_RESP;
        ST_CLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) r_state <= ST_RESP;
        end
        ST_RESP: if (resp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is a pure decode of state, so reset drops mem_we immediately
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      ST_RD: mem_addr = ADDR_W'(r_addr_a);
      ST_WR: begin
        mem_addr  = ADDR_W'(r_addr_a);
        mem_we    = 1'b1;
        mem_wdata = r_wdata;
      end
      ST_SWP_B: begin
        mem_addr  = ADDR_W'(r_addr_b);
        mem_we    = 1'b1;
        mem_wdata = r_tmp_a;
      end
      ST_SWP_A: begin
        mem_addr  = ADDR_W'(r_addr_a);
        mem_we    = 1'b1;
        mem_wdata = r_tmp_b;
      end
      ST_CLR: begin
        mem_addr = ADDR_W'(r_cnt);
        mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [25:0] req_addr_a;
  logic [25:0] req_addr_b;
  logic [25:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [25:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [25:0] mem_addr;
  logic        mem_we;
  logic [25:0] mem_wdata;
  logic [25:0] mem_rdata;

  logic [25:0] mem [8];
  logic [25:0] we_addr [16];
  int          n_checks = 0;
  int          n_fails  = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge
  assign mem_rdata = mem[mem_addr[2:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[2:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [25:0] a, input logic [25:0] b,
                       input logic [25:0] wd, input bit hold,
                       output logic [25:0] data, output logic err,
                       output int lat, output int wecnt);
    int n;
    @(negedge clk);
    req_op = op; req_addr_a = a; req_addr_b = b; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; wecnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        if (wecnt < 16) we_addr[wecnt] = mem_addr;
        wecnt++;
      end
    end while (!resp_valid && lat < 40);
    if (!resp_valid) chk("resp_timeout", 0, 1);
    data = resp_data;
    err  = resp_err;
    if (!hold) begin
      chk("req_ready_in_resp", req_ready, 0);
      resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
    end
  endtask

  logic [25:0] d;
  logic        e;
  int          lat, wc;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr_a = '0; req_addr_b = '0;
    req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    do_op(2'b01, 26'd3, 26'd0, 26'h2AAAAAA, 0, d, e, lat, wc);
    chk("wr_err", e, 0);
    chk("wr_data", d, 0);
    chk("wr_we_cnt", wc, 1);
    chk("wr_we_addr", we_addr[0], 3);
    chk("wr_mem3", mem[3], 26'h2AAAAAA);

    do_op(2'b00, 26'd3, 26'd0, 26'd0, 0, d, e, lat, wc);
    chk("rd_data", d, 26'h2AAAAAA);
    chk("rd_err", e, 0);
    chk("rd_latency", lat, 2);
    chk("rd_we_cnt", wc, 0);

    do_op(2'b01, 26'd1, 26'd0, 26'h11, 0, d, e, lat, wc);
    do_op(2'b01, 26'd4, 26'd0, 26'h44, 0, d, e, lat, wc);
    do_op(2'b10, 26'd1, 26'd4, 26'd0, 0, d, e, lat, wc);
    chk("swp_data", d, 26'h11);
    chk("swp_err", e, 0);
    chk("swp_we_cnt", wc, 2);
    chk("swp_latency", lat, 4);
    chk("swp_mem1", mem[1], 26'h44);
    chk("swp_mem4", mem[4], 26'h11);

    do_op(2'b01, 26'd2, 26'd0, 26'h222, 0, d, e, lat, wc);
    do_op(2'b10, 26'd2, 26'd2, 26'd0, 0, d, e, lat, wc);
    chk("swp_same_data", d, 26'h222);
    chk("swp_same_mem2", mem[2], 26'h222);

    do_op(2'b01, 26'd8, 26'd0, 26'h3FFFFFF, 0, d, e, lat, wc);
    chk("wr_oor_err", e, 1);
    chk("wr_oor_data", d, 0);
    chk("wr_oor_we_cnt", wc, 0);
    chk("wr_oor_latency", lat, 1);

    do_op(2'b01, 26'd0, 26'd0, 26'h5A, 0, d, e, lat, wc);
    do_op(2'b10, 26'd0, 26'd9, 26'd0, 0, d, e, lat, wc);
    chk("swp_oor_err", e, 1);
    chk("swp_oor_we_cnt", wc, 0);
    chk("swp_oor_mem0", mem[0], 26'h5A);
    chk("swp_oor_mem1", mem[1], 26'h44);

    do_op(2'b00, 26'd0, 26'd0, 26'd0, 0, d, e, lat, wc);
    chk("err_cleared", e, 0);
    chk("rd0_data", d, 26'h5A);

    for (int i = 0; i < 8; i++) do_op(2'b01, 26'(i), 26'd0, 26'(i + 1), 0, d, e, lat, wc);
    do_op(2'b11, 26'h3FFFFFF, 26'h3FFFFFF, 26'd0, 0, d, e, lat, wc);
    chk("clr_we_cnt", wc, 8);
    chk("clr_latency", lat, 9);
    chk("clr_err", e, 0);
    chk("clr_data", d, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_addr%0d", i), we_addr[i], i);
      chk($sformatf("clr_mem%0d", i), mem[i], 0);
    end

    do_op(2'b01, 26'd6, 26'd0, 26'h1234567, 0, d, e, lat, wc);
    do_op(2'b00, 26'd6, 26'd0, 26'd0, 1, d, e, lat, wc);
    chk("hold_first_data", d, 26'h1234567);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_data", resp_data, 26'h1234567);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release_req_ready", req_ready, 1);
    chk("release_resp_valid", resp_valid, 0);
    req_op = 2'b00; req_addr_a = 26'd6; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("next_accept_busy", busy, 1);
    @(negedge clk);
    chk("next_resp_valid", resp_valid, 1);
    chk("next_resp_data", resp_data, 26'h1234567);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    do_op(2'b01, 26'd5, 26'd0, 26'h55, 0, d, e, lat, wc);
    do_op(2'b01, 26'd7, 26'd0, 26'h77, 0, d, e, lat, wc);
    @(negedge clk);
    req_op = 2'b10; req_addr_a = 26'd5; req_addr_b = 26'd7; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_swp_we", mem_we, 1);
    chk("mid_swp_addr", mem_addr, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem7", mem[7], 26'h77);
    chk("abort_mem5", mem[5], 26'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer sitting directly upstream of the 8-entry, 26-bit data memory. It accepts load/store/swap/clear requests from the CPU execute stage over a valid/ready handshake. It drives the memory's single shared address, write-enable and write-data port, and returns a response over a valid/ready handshake. SWAP exchanges two puzzle tiles in memory; CLEAR zeroes the board.

Parameters:
DATA_W, 26, data word width (matches memory in/out)
ADDR_W, 26, memory address port width
DEPTH_LOG2, 3, log2 of implemented entries (8); valid addresses 0..7

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_op  input  2  00 READ, 01 WRITE, 10 SWAP, 11 CLEAR
req_addr_a  input  ADDR_W  primary address
req_addr_b  input  ADDR_W  second address (SWAP only)
req_wdata  input  DATA_W  write data (WRITE only)
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_data  output  DATA_W  READ: word read; SWAP: old mem[a]; WRITE/CLEAR: 0
resp_err  output  1  request rejected: address out of range
busy  output  1  state != IDLE
mem_addr  output  ADDR_W  to memory addr
mem_we  output  1  to memory we
mem_wdata  output  DATA_W  to memory in
mem_rdata  input  DATA_W  from memory out (combinational read of mem[mem_addr])

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (rst_n). Reset forces state IDLE and clears all registers.
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Memory model: reads are combinational; writes land on the next posedge when mem_we=1. A read and write to the same address in one cycle returns the old value.
- mem_addr, mem_we and mem_wdata are decoded from state plus latched operands. mem_we is never 1 outside the write states below.
- Mid-operation reset aborts the sequence immediately (mem_we drops asynchronously). The memory is not cleared by this block.
- States: IDLE, RD, WR, SWP_B, SWP_A, CLR, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op, both addresses and wdata.
  - Range check: addr_a (and addr_b for SWAP) must have bits [ADDR_W-1:DEPTH_LOG2] all zero.
  - If the check fails, go to RESP with resp_err=1 and resp_data=0. No memory write occurs.
  - CLEAR performs no range check.
  - Otherwise go to RD, WR, SWP_B (via a read cycle, see SWAP) or CLR.
- READ: RD drives mem_addr=a, we=0 and captures mem_rdata, then goes to RESP. resp_valid asserts 2 cycles after acceptance.
- WRITE: WR drives mem_addr=a, we=1, wdata=req_wdata, then goes to RESP.
- SWAP (3 memory cycles):
  - Cycle 1 (RD with swap flag): addr=a, capture tmp_a.
  - Cycle 2 (SWP_B): addr=b, we=1, wdata=tmp_a, capture tmp_b=old mem[b].
  - Cycle 3 (SWP_A): addr=a, we=1, wdata=tmp_b, then go to RESP with resp_data=tmp_a.
  - a==b leaves memory unchanged.
- CLEAR: 3-bit counter starting at 0. In CLR, addr=cnt, we=1, wdata=0. After cnt=7 go to RESP. Takes exactly 8 write cycles.
- RESP: resp_valid=1, and resp_data/resp_err held stable until resp_ready. On resp_ready, go to IDLE; resp_valid drops next cycle.
- No new request is accepted in the cycle the response handshakes; req_ready rises the following cycle.
- resp_err clears on the next acceptance.

Decomposition:
- Shared package mem_pkg:
  - Op codes OP_READ, OP_WRITE, OP_SWAP, OP_CLEAR.
  - State enum.
  - MEM_DEPTH=8 and MEM_DEPTH_LOG2=3.
  - DATA_W/ADDR_W defaults, also used by the memory.
- Single module; no sub-module is warranted. The range check is a local function.

Test Plan:
- Reset mid-SWAP: assert rst_n=0 during SWP_B -> mem_we=0 same cycle, req_ready=1, resp_valid=0. Memory mem[b] is already written only if a posedge with we=1 preceded reset.
- WRITE a=3 data=0x2AAAAAA, then READ a=3 -> resp_data=0x2AAAAAA, resp_err=0, resp_valid exactly 2 cycles after READ accept.
- Preload mem[1]=0x11, mem[4]=0x44; SWAP a=1 b=4 -> mem[1]=0x44, mem[4]=0x11, resp_data=0x11. Exactly 2 cycles with mem_we=1. SWAP a=2 b=2 -> mem[2] unchanged.
- WRITE a=8 -> resp_err=1, resp_data=0, mem_we never asserted. SWAP a=0 b=9 -> resp_err=1, memory unchanged.
- CLEAR after filling all entries with nonzero values -> 8 consecutive mem_we cycles with addr 0..7, then all entries read 0.
- Hold resp_ready=0 for 5 cycles after a READ -> resp_valid and resp_data stable, req_ready=0, busy=1. Raise resp_ready -> IDLE next cycle, a new request is accepted one cycle later.
